// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver (and the future transmitter).
//   rx_state_e  - receiver FSM states
//   OVERSAMPLE  - ticks per bit (16)
//   SAMPLE_*    - sample counts at which the line is captured (7, 8, 9)
//   DATA_BITS   - data bits per frame (8)
//   maj3()      - 2-of-3 majority vote
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick generator.
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset
//   clear  - holds the divider at 0 (restart point of the bit timing)
//   tick   - one-cycle pulse every DIV clocks, DIV = CLK_FREQ/(BAUD*OVERSAMPLE)
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = !clear && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, 16x oversampled.
//   CLOCK_50   - system clock
//   RESET_N    - asynchronous active-low reset
//   UART_RX    - raw serial line (idle high, asynchronous)
//   RX_DATA    - received byte, stable while RX_VALID
//   RX_VALID   - byte available
//   RX_READY   - consumer accepts on RX_VALID && RX_READY
//   RX_FERR    - framing error of the byte in RX_DATA
//   RX_OVERRUN - one-cycle pulse when a completed byte is dropped
//   RX_BUSY    - receiver not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_FERR,
    output logic       RX_OVERRUN,
    output logic       RX_BUSY
);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic       s_lo_q, s_lo_d, s_mid_q, s_mid_d;
    logic [7:0] shift_q, shift_d, data_q, data_d;
    logic       valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

    logic       rx_s, tick, maj, decide, bit_end;
    logic [3:0] scnt_nxt;

    assign rx_s = sync_q[1];

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET_N),
        .clear  (state_q == IDLE),
        .tick   (tick)
    );

    // scnt counts ticks elapsed in the current bit; the captures happen on
    // the ticks that bring it to 7 and 8, and the vote on the tick that
    // brings it to 9, i.e. about 0.56 bit after the bit's leading edge.
    assign scnt_nxt = scnt_q + 4'd1;
    assign decide   = tick && (scnt_nxt == 4'(SAMPLE_HI));
    assign bit_end  = tick && (scnt_q == 4'(OVERSAMPLE - 1));
    assign maj      = maj3(s_lo_q, s_mid_q, rx_s);

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bidx_d  = bidx_q;
        s_lo_d  = s_lo_q;
        s_mid_d = s_mid_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        if (tick) begin
            scnt_d = scnt_nxt;
            if (scnt_nxt == 4'(SAMPLE_LO))  s_lo_d  = rx_s;
            if (scnt_nxt == 4'(SAMPLE_MID)) s_mid_d = rx_s;
        end

        if (valid_q && RX_READY) valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                scnt_d = '0;
                bidx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (decide && maj)  state_d = IDLE;   // false start
                else if (bit_end) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
            end
            DATA: begin
                if (decide) shift_d = {maj, shift_q[7:1]};
                if (bit_end) begin
                    if (bidx_q == 3'(DATA_BITS - 1)) state_d = STOP;
                    else                             bidx_d  = bidx_q + 3'd1;
                end
            end
            STOP: begin
                if (decide) begin
                    // A held byte that is accepted this very cycle makes room.
                    if (!valid_q || RX_READY) begin
                        data_d  = shift_q;
                        ferr_d  = !maj;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                    state_d = maj ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            s_lo_q  <= 1'b1;
            s_mid_q <= 1'b1;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], UART_RX};
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bidx_q  <= bidx_d;
            s_lo_q  <= s_lo_d;
            s_mid_q <= s_mid_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_DATA    = data_q;
    assign RX_VALID   = valid_q;
    assign RX_FERR    = ferr_q;
    assign RX_OVERRUN = ovr_q;
    assign RX_BUSY    = (state_q != IDLE);

endmodule
